// File: rtl/atm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// atm_pkg : shared types and constants for the account ledger
// Revision: 1.0
// ---------------------------------------------------------------------
package atm_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic [2:0] REASON_NONE         = 3'd0;
   localparam logic [2:0] REASON_NO_SESSION   = 3'd1;
   localparam logic [2:0] REASON_INSUFFICIENT = 3'd2;
   localparam logic [2:0] REASON_LIMIT        = 3'd3;
   localparam logic [2:0] REASON_FULL         = 3'd4;
   localparam logic [2:0] REASON_CONFLICT     = 3'd5;

   localparam int BCD_DIGITS = 4;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ---------------------------------------------------------------------
// bcd_digit_counter : one BCD digit with load, wrap-around inc and dec
// Revision: 1.0
// ---------------------------------------------------------------------
module bcd_digit_counter (
   input  logic       clk,
   input  logic       load,
   input  logic [3:0] load_value,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] digit,
   output logic       is_nine,
   output logic       is_zero
);

   assign is_nine = (digit == 4'd9);
   assign is_zero = (digit == 4'd0);

   // load outranks counting so a reset cycle drops any pending request
   always_ff @(posedge clk) begin
      if (load) begin
         digit <= load_value;
      end else if (inc) begin
         digit <= is_nine ? 4'd0 : digit + 4'd1;
      end else if (dec) begin
         digit <= is_zero ? 4'd9 : digit - 4'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/account_balance.sv
`default_nettype none
// ---------------------------------------------------------------------
// account_balance : BCD ledger with session gating and request checks
// Revision: 1.0
// ---------------------------------------------------------------------
module account_balance
   import atm_pkg::*;
#(
   parameter logic [15:0] INIT_BALANCE  = 16'h0100,
   parameter int          SESSION_LIMIT = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        session_start,
   input  logic        session_end,
   input  logic        count_up,
   input  logic        count_down,
   output logic [15:0] balance_bcd,
   output logic        session_active,
   output logic [6:0]  withdrawn_count,
   output logic        accepted,
   output logic        denied,
   output logic [2:0]  reason
);

   localparam logic [6:0] LIMIT_COUNT = 7'(SESSION_LIMIT);

   state_t state;
   state_t state_next;

   logic [BCD_DIGITS-1:0] is_nine;
   logic [BCD_DIGITS-1:0] is_zero;
   logic [BCD_DIGITS-1:0] dig_inc;
   logic [BCD_DIGITS-1:0] dig_dec;
   logic [3:0]            digit [BCD_DIGITS];

   logic       do_inc;
   logic       do_dec;
   logic       acc_next;
   logic       den_next;
   logic [2:0] reason_next;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (session_start) state_next = ACTIVE;
         ACTIVE:  if (session_end)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // priority order decides which reason wins when several apply
   always_comb begin
      do_inc      = 1'b0;
      do_dec      = 1'b0;
      acc_next    = 1'b0;
      den_next    = 1'b0;
      reason_next = REASON_NONE;
      if (count_up || count_down) begin
         if (state != ACTIVE) begin
            den_next    = 1'b1;
            reason_next = REASON_NO_SESSION;
         end else if (count_up && count_down) begin
            den_next    = 1'b1;
            reason_next = REASON_CONFLICT;
         end else if (count_down && (&is_zero)) begin
            den_next    = 1'b1;
            reason_next = REASON_INSUFFICIENT;
         end else if (count_down && (withdrawn_count == LIMIT_COUNT)) begin
            den_next    = 1'b1;
            reason_next = REASON_LIMIT;
         end else if (count_up && (&is_nine)) begin
            den_next    = 1'b1;
            reason_next = REASON_FULL;
         end else begin
            acc_next = 1'b1;
            do_inc   = count_up;
            do_dec   = count_down;
         end
      end
   end

   // a digit steps only when every lower digit is about to wrap
   generate
      for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
         if (i == 0) begin : g_lsd
            assign dig_inc[i] = do_inc;
            assign dig_dec[i] = do_dec;
         end else begin : g_upper
            assign dig_inc[i] = do_inc & (&is_nine[i-1:0]);
            assign dig_dec[i] = do_dec & (&is_zero[i-1:0]);
         end

         bcd_digit_counter u_digit (
            .clk        (clk),
            .load       (reset),
            .load_value (INIT_BALANCE[4*i +: 4]),
            .inc        (dig_inc[i]),
            .dec        (dig_dec[i]),
            .digit      (digit[i]),
            .is_nine    (is_nine[i]),
            .is_zero    (is_zero[i])
         );

         assign balance_bcd[4*i +: 4] = digit[i];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         session_active  <= 1'b0;
         withdrawn_count <= 7'd0;
         accepted        <= 1'b0;
         denied          <= 1'b0;
         reason          <= REASON_NONE;
      end else begin
         state          <= state_next;
         session_active <= (state_next == ACTIVE);
         if ((state == IDLE) && (state_next == ACTIVE)) begin
            withdrawn_count <= 7'd0;
         end else if (do_dec) begin
            withdrawn_count <= withdrawn_count + 7'd1;
         end
         accepted <= acc_next;
         denied   <= den_next;
         reason   <= reason_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_account_balance.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_account_balance : three parameterisations driven with shared stimulus
// Revision: 1.0
// ---------------------------------------------------------------------
module tb_account_balance;

   localparam int N = 3;

   typedef struct packed {
      logic [15:0] bal;
      logic        act;
      logic [6:0]  wc;
      logic        acc;
      logic        den;
      logic [2:0]  rsn;
   } exp_t;

   logic clk           = 1'b0;
   logic reset         = 1'b1;
   logic session_start = 1'b0;
   logic session_end   = 1'b0;
   logic count_up      = 1'b0;
   logic count_down    = 1'b0;

   logic [15:0] bal_o [N];
   logic        act_o [N];
   logic [6:0]  wc_o  [N];
   logic        acc_o [N];
   logic        den_o [N];
   logic [2:0]  rsn_o [N];

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb [N][$];

   int lim_m  [N] = '{20, 3, 2};
   int init_m [N] = '{100, 1, 9999};
   int bal_m  [N];
   int wc_m   [N];
   bit act_m  [N];

   always #5 clk = ~clk;

   account_balance #(.INIT_BALANCE(16'h0100), .SESSION_LIMIT(20)) u_dut0 (
      .clk(clk), .reset(reset), .session_start(session_start), .session_end(session_end),
      .count_up(count_up), .count_down(count_down), .balance_bcd(bal_o[0]),
      .session_active(act_o[0]), .withdrawn_count(wc_o[0]), .accepted(acc_o[0]),
      .denied(den_o[0]), .reason(rsn_o[0]));

   account_balance #(.INIT_BALANCE(16'h0001), .SESSION_LIMIT(3)) u_dut1 (
      .clk(clk), .reset(reset), .session_start(session_start), .session_end(session_end),
      .count_up(count_up), .count_down(count_down), .balance_bcd(bal_o[1]),
      .session_active(act_o[1]), .withdrawn_count(wc_o[1]), .accepted(acc_o[1]),
      .denied(den_o[1]), .reason(rsn_o[1]));

   account_balance #(.INIT_BALANCE(16'h9999), .SESSION_LIMIT(2)) u_dut2 (
      .clk(clk), .reset(reset), .session_start(session_start), .session_end(session_end),
      .count_up(count_up), .count_down(count_down), .balance_bcd(bal_o[2]),
      .session_active(act_o[2]), .withdrawn_count(wc_o[2]), .accepted(acc_o[2]),
      .denied(den_o[2]), .reason(rsn_o[2]));

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // the ledger rules in integer arithmetic; returns the next-cycle outputs
   function automatic exp_t model_step(input int i, input bit r, input bit ss,
                                       input bit se, input bit up, input bit dn);
      exp_t e;
      e = '0;
      if (r) begin
         bal_m[i] = init_m[i];
         wc_m[i]  = 0;
         act_m[i] = 1'b0;
      end else begin
         if (up || dn) begin
            e.den = 1'b1;
            if (!act_m[i])                  e.rsn = 3'd1;
            else if (up && dn)              e.rsn = 3'd5;
            else if (dn && bal_m[i] == 0)   e.rsn = 3'd2;
            else if (dn && wc_m[i] == lim_m[i]) e.rsn = 3'd3;
            else if (up && bal_m[i] == 9999) e.rsn = 3'd4;
            else begin
               e.den = 1'b0;
               e.acc = 1'b1;
               bal_m[i] = bal_m[i] + (up ? 1 : -1);
               if (dn) wc_m[i] = wc_m[i] + 1;
            end
         end
         if (!act_m[i] && ss) begin
            act_m[i] = 1'b1;
            wc_m[i]  = 0;
         end else if (act_m[i] && se) begin
            act_m[i] = 1'b0;
         end
      end
      e.bal = to_bcd(bal_m[i]);
      e.act = act_m[i];
      e.wc  = 7'(wc_m[i]);
      return e;
   endfunction

   task automatic step(input bit r, input bit ss, input bit se, input bit up, input bit dn);
      @(negedge clk);
      reset         = r;
      session_start = ss;
      session_end   = se;
      count_up      = up;
      count_down    = dn;
      for (int i = 0; i < N; i++) sb[i].push_back(model_step(i, r, ss, se, up, dn));
   endtask

   // monitor: registered outputs reflect the cycle driven before this edge
   initial begin
      exp_t e;
      exp_t got;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (sb[i].size() > 0) begin
               e   = sb[i].pop_front();
               got = {bal_o[i], act_o[i], wc_o[i], acc_o[i], den_o[i], rsn_o[i]};
               n_checks++;
               if (got !== e) begin
                  n_fail++;
                  $display("FAIL dut%0d t=%0t got bal=%h act=%b wc=%0d acc=%b den=%b rsn=%0d required bal=%h act=%b wc=%0d acc=%b den=%b rsn=%0d",
                           i, $time, got.bal, got.act, got.wc, got.acc, got.den, got.rsn,
                           e.bal, e.act, e.wc, e.acc, e.den, e.rsn);
               end
            end
         end
      end
   end

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);            // withdraw while idle
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1);            // request alongside session_start
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);            // back-to-back withdraws
      step(0, 0, 0, 1, 0);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 1);            // conflict
      step(0, 0, 1, 0, 1);            // request alongside session_end
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1);            // reset mid-session with a request
      step(0, 0, 0, 0, 0);
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 4,
              $urandom_range(0, 99) < 40,
              $urandom_range(0, 99) < 45);
      end
      step(0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (sb[i].size() != 0) begin
            n_fail++;
            $display("FAIL dut%0d drain: %0d entries left, required 0", i, sb[i].size());
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
